pipe_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB). It detects load-use hazards, flushes wrong-path instructions when a branch resolves taken in MEM, and freezes the whole pipeline while a multi-cycle data memory access is pending. It drives write-enable, bubble and flush controls into the PC, IF2ID, ID2EXE and EXE2MEM registers, and contains a small FSM with stall and timeout counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Pipeline stage status and control signals for pipe_hazard_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_dest;
  logic       mem_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       if2id_write;
  logic       if2id_flush;
  logic       id2exe_bubble;
  logic       exe2mem_flush;
  logic       pipe_hold;
  logic       mem_timeout_err;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest,
           mem_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if2id_write, if2id_flush, id2exe_bubble,
           exe2mem_flush, pipe_hold, mem_timeout_err, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dest,
           mem_branch_taken, dmem_req, dmem_ready,
    output pc_write, if2id_write, if2id_flush, id2exe_bubble,
           exe2mem_flush, pipe_hold, mem_timeout_err, state
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Load-use / branch-flush / memory-wait sequencer for a 5-stage MIPS
//          pipeline. Optional HAZARD_PERF_EN adds saturating perf counters.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  wire logic         clock,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [CNT_W-1:0]  perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_HALT_ERR   = 2'd3
  } state_t;

  localparam logic [2:0] c_stall_init = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [8:0] c_timeout    = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       resume_q, resume_d;
  logic       err_q, err_d;

  logic       w_hazard, w_mem_stall, w_ld_bubble, w_br_flush;
  logic [8:0] w_wait_inc;
  logic       w_pc_write, w_if2id_write, w_if2id_flush;
  logic       w_bubble, w_exe2mem_flush, w_pipe_hold;

  assign w_hazard = bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
                    ((bus.ex_dest == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));
  assign w_mem_stall = bus.dmem_req && !bus.dmem_ready;
  assign w_wait_inc  = {1'b0, wait_cnt_q} + 9'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      resume_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      resume_q    <= resume_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_cnt_d     = stall_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    resume_d        = resume_q;
    err_d           = err_q;
    w_pc_write      = 1'b1;
    w_if2id_write   = 1'b1;
    w_if2id_flush   = 1'b0;
    w_bubble        = 1'b0;
    w_exe2mem_flush = 1'b0;
    w_pipe_hold     = 1'b0;
    w_ld_bubble     = 1'b0;
    w_br_flush      = 1'b0;
    case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (w_mem_stall) begin
          // Stall count is left untouched so a preempted load stall resumes.
          w_pipe_hold   = 1'b1;
          w_pc_write    = 1'b0;
          w_if2id_write = 1'b0;
          state_d       = ST_MEM_WAIT;
          wait_cnt_d    = 8'd1;
          resume_d      = (state_q == ST_LOAD_STALL);
        end else if (bus.mem_branch_taken) begin
          w_if2id_flush   = 1'b1;
          w_bubble        = 1'b1;
          w_exe2mem_flush = 1'b1;
          w_br_flush      = 1'b1;
          state_d         = ST_RUN;
        end else if (state_q == ST_LOAD_STALL || w_hazard) begin
          w_pc_write    = 1'b0;
          w_if2id_write = 1'b0;
          w_bubble      = 1'b1;
          w_ld_bubble   = 1'b1;
          if (state_q == ST_RUN) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_d     = ST_LOAD_STALL;
              stall_cnt_d = c_stall_init;
            end
          end else if (stall_cnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 3'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d    = resume_q ? ST_LOAD_STALL : ST_RUN;
          resume_d   = 1'b0;
          wait_cnt_d = 8'd0;
        end else begin
          w_pipe_hold   = 1'b1;
          w_pc_write    = 1'b0;
          w_if2id_write = 1'b0;
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = w_wait_inc[7:0];
          end
          if (w_wait_inc >= c_timeout) begin
            err_d   = 1'b1;
            state_d = ST_HALT_ERR;
          end
        end
      end
      default: begin
        w_pipe_hold   = 1'b1;
        w_pc_write    = 1'b0;
        w_if2id_write = 1'b0;
      end
    endcase
    // Outputs must be safe as soon as reset rises, before any clock edge.
    if (reset) begin
      w_pc_write      = 1'b0;
      w_if2id_write   = 1'b0;
      w_if2id_flush   = 1'b0;
      w_bubble        = 1'b0;
      w_exe2mem_flush = 1'b0;
      w_pipe_hold     = 1'b1;
      w_ld_bubble     = 1'b0;
      w_br_flush      = 1'b0;
    end
  end

  assign bus.pc_write        = w_pc_write;
  assign bus.if2id_write     = w_if2id_write;
  assign bus.if2id_flush     = w_if2id_flush;
  assign bus.id2exe_bubble   = w_bubble;
  assign bus.exe2mem_flush   = w_exe2mem_flush;
  assign bus.pipe_hold       = w_pipe_hold;
  assign bus.mem_timeout_err = err_q;
  assign bus.state           = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_wait_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (w_ld_bubble && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if (w_br_flush && (perf_flush_q != '1))  perf_flush_q <= perf_flush_q + 1'b1;
      if ((state_q == ST_MEM_WAIT) && (perf_wait_q != '1)) perf_wait_q <= perf_wait_q + 1'b1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_wait_cnt  = perf_wait_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed scoreboard bench for pipe_hazard_ctrl (two configurations).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if if_a ();
  pipe_hazard_ctrl_if if_b ();

`ifdef HAZARD_PERF_EN
  logic [15:0] a_ps, a_pf, a_pw, b_ps, b_pf, b_pw;
`endif

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(16)) u_a (
    .clock(clk), .reset(rst), .bus(if_a.slave)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf), .perf_wait_cnt(a_pw)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u_b (
    .clock(clk), .reset(rst), .bus(if_b.slave)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf), .perf_wait_cnt(b_pw)
`endif
  );

  // Output vector: {pc_write, if2id_write, if2id_flush, id2exe_bubble, exe2mem_flush, pipe_hold}
  localparam logic [5:0] O_RUN  = 6'b110000;
  localparam logic [5:0] O_BUB  = 6'b000100;
  localparam logic [5:0] O_FL   = 6'b111110;
  localparam logic [5:0] O_HOLD = 6'b000001;
  localparam logic [5:0] O_RST  = 6'b000001;

  typedef struct {
    string      tag;
    int         dut;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [8:0] obs(input int d);
    if (d == 0)
      return {if_a.pc_write, if_a.if2id_write, if_a.if2id_flush, if_a.id2exe_bubble,
              if_a.exe2mem_flush, if_a.pipe_hold, if_a.mem_timeout_err, if_a.state};
    return {if_b.pc_write, if_b.if2id_write, if_b.if2id_flush, if_b.id2exe_bubble,
            if_b.exe2mem_flush, if_b.pipe_hold, if_b.mem_timeout_err, if_b.state};
  endfunction

  task automatic drive(input int d, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] dst,
                       input logic br, input logic req, input logic rdy);
    if (d == 0) begin
      if_a.id_rs = rs; if_a.id_rt = rt; if_a.id_uses_rt = urt; if_a.ex_mem_read = mr;
      if_a.ex_dest = dst; if_a.mem_branch_taken = br; if_a.dmem_req = req; if_a.dmem_ready = rdy;
    end else begin
      if_b.id_rs = rs; if_b.id_rt = rt; if_b.id_uses_rt = urt; if_b.ex_mem_read = mr;
      if_b.ex_dest = dst; if_b.mem_branch_taken = br; if_b.dmem_req = req; if_b.dmem_ready = rdy;
    end
  endtask

  // One clock cycle: drive after the rising edge, push expectation, compare on the falling edge.
  task automatic cyc(input int d, input string tag, input logic r,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic mr, input logic [4:0] dst, input logic br,
                     input logic req, input logic rdy,
                     input logic [5:0] o, input logic err, input logic [1:0] st);
    sb_t        e;
    logic [8:0] got;
    @(posedge clk);
    #1;
    rst = r;
    drive(d, rs, rt, urt, mr, dst, br, req, rdy);
    sb_q.push_back('{tag: tag, dut: d, exp: {o, err, st}});
    @(negedge clk);
    e   = sb_q.pop_front();
    got = obs(e.dut);
    checks++;
    assert (got === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", e.tag, got, e.exp);
    end
  endtask

  initial begin
    drive(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset state and first RUN cycle
    cyc(0, "rst_a",      1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 2'd0);
    cyc(1, "rst_b",      1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 2'd0);
    cyc(0, "run_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2'd0);

    // Load-use, single bubble configuration
    cyc(0, "lu_rs",      0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB, 0, 2'd0);
    cyc(0, "lu_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2'd0);
    cyc(0, "lu_r0",      0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN, 0, 2'd0);
    cyc(0, "lu_rt_nouse",0, 3, 8, 0, 1, 8, 0, 0, 0, O_RUN, 0, 2'd0);
    cyc(0, "lu_rt_use",  0, 3, 8, 1, 1, 8, 0, 0, 0, O_BUB, 0, 2'd0);
    cyc(0, "br_hazard",  0, 8, 0, 0, 1, 8, 1, 0, 0, O_FL,  0, 2'd0);
    cyc(0, "br_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2'd0);

    // Memory wait of three stalled cycles then ready
    cyc(0, "mw_1",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd0);
    cyc(0, "mw_2",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "mw_3",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "mw_ready",   0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN,  0, 2'd2);
    cyc(0, "mw_back",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 2'd0);

    // Timeout after four stalled cycles, sticky until reset
    cyc(0, "to_1",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd0);
    cyc(0, "to_2",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "to_3",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "to_4",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "to_halt",    0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 1, 2'd3);
    cyc(0, "to_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 1, O_HOLD, 1, 2'd3);
    cyc(0, "to_rst",     1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 2'd0);
    cyc(0, "to_rel",     0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 2'd0);

    // Reset asserted in the middle of a memory wait
    cyc(0, "mr_1",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd0);
    cyc(0, "mr_2",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(0, "mr_rst",     1, 0, 0, 0, 0, 0, 0, 1, 0, O_RST,  0, 2'd0);
    cyc(0, "mr_rel",     0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 2'd0);

    // Three-cycle load stall configuration
    cyc(1, "ls_1",       0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB, 0, 2'd0);
    cyc(1, "ls_2",       0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB, 0, 2'd1);
    cyc(1, "ls_3",       0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB, 0, 2'd1);
    cyc(1, "ls_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2'd0);

    // Branch aborts the stall in its second cycle
    cyc(1, "ab_1",       0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB, 0, 2'd0);
    cyc(1, "ab_br",      0, 8, 0, 0, 1, 8, 1, 0, 0, O_FL,  0, 2'd1);
    cyc(1, "ab_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0, 2'd0);

    // Memory wait preempts the stall, which then resumes with its remaining count
    cyc(1, "pe_1",       0, 8, 0, 0, 1, 8, 0, 0, 0, O_BUB,  0, 2'd0);
    cyc(1, "pe_mem",     0, 8, 0, 0, 1, 8, 0, 1, 0, O_HOLD, 0, 2'd1);
    cyc(1, "pe_wait",    0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD, 0, 2'd2);
    cyc(1, "pe_ready",   0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN,  0, 2'd2);
    cyc(1, "pe_res_1",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB,  0, 2'd1);
    cyc(1, "pe_res_2",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB,  0, 2'd1);
    cyc(1, "pe_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
